systolic_stream_ctrl: RTL and testbench

- Stream controller that wraps the three-slice systolic array.
- Upstream side: accepts X samples over a valid/ready handshake and drives the array's x_in and y_prev_0 every cycle.
- Downstream side: tracks each issued sample through the array's fixed latency, captures the matching y_out_2 into an output FIFO, and presents results over valid/ready.
- Credit-based issue guarantees no result is ever dropped under downstream backpressure.

---
 rtl/systolic_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 54 +++++
 rtl/systolic_stream_ctrl.sv | 135 +++++++++++++
 tb/tb_systolic_stream_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and default sizing for the systolic array stream controller.
package systolic_pkg;

  localparam int WIDTH_DEF        = 8;
  localparam int LATENCY_DEF      = 3;
  localparam int DEPTH_DEF        = 4;
  localparam int FLUSH_CYCLES_DEF = 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } ctrl_state_t;

  typedef struct packed {
    logic valid;
    logic last;
  } dl_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; the head reads as zero while empty.
module sync_fifo #(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              full;
  logic              pop_ok;
  logic              push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  // a pop in the same cycle frees the slot, so a full FIFO can still accept
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/systolic_stream_ctrl.sv
// Valid/ready stream wrapper around the systolic array: credit-gated issue,
// latency tracking of issued samples and an output FIFO for the results.
module systolic_stream_ctrl
  import systolic_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEF,
  parameter int LATENCY      = LATENCY_DEF,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [WIDTH-1:0] s_data,
  input  logic                    s_last,
  output logic signed [WIDTH-1:0] arr_x_in,
  output logic signed [WIDTH-1:0] arr_y_prev,
  input  logic signed [WIDTH-1:0] arr_y_out,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [WIDTH-1:0] m_data,
  output logic                    m_last,
  output logic                    busy
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int IW  = $clog2(LATENCY + 2);
  localparam int FCW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FCW-1:0] FLUSH_INIT = FCW'(FLUSH_CYCLES - 1);

  ctrl_state_t      state;
  logic [FCW-1:0]   flush_cnt;
  logic             issue;
  logic             credit_ok;
  logic [IW-1:0]    inflight;

  logic             vld_p0;
  logic             last_p0;
  dl_entry_t        dl_p1 [LATENCY];
  dl_entry_t        tail;

  logic [WIDTH:0]   fifo_head;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;

  // vld_p0 is the sample currently on arr_x_in; it counts against credit too
  always_comb begin
    inflight = IW'(vld_p0);
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + IW'(dl_p1[i].valid);
    end
  end

  assign credit_ok = (32'(fifo_count) + 32'(inflight)) < 32'(DEPTH);
  assign s_ready   = rst && (state != FLUSH) && credit_ok;
  assign issue     = s_valid && s_ready;

  // Stage p0: registered sample onto the array input, bubble otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arr_x_in <= '0;
      vld_p0   <= 1'b0;
      last_p0  <= 1'b0;
    end else begin
      arr_x_in <= issue ? s_data : '0;
      vld_p0   <= issue;
      last_p0  <= issue && s_last;
    end
  end

  // Stage p1: LATENCY-deep tag line whose tail lines up with arr_y_out
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LATENCY; i++) dl_p1[i] <= '0;
    end else begin
      dl_p1[0] <= '{valid: vld_p0, last: last_p0};
      for (int i = 1; i < LATENCY; i++) dl_p1[i] <= dl_p1[i-1];
    end
  end

  assign tail = dl_p1[LATENCY-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      flush_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            if (s_last) begin
              state     <= FLUSH;
              flush_cnt <= FLUSH_INIT;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (issue && s_last) begin
            state     <= FLUSH;
            flush_cnt <= FLUSH_INIT;
          end
        end
        FLUSH: begin
          if (flush_cnt == '0) state <= IDLE;
          else                 flush_cnt <= flush_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .DATA_W (WIDTH + 1),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tail.valid),
    .push_data ({tail.last, arr_y_out}),
    .pop       (m_valid && m_ready),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign m_valid    = !fifo_empty;
  assign m_data     = fifo_head[WIDTH-1:0];
  assign m_last     = fifo_head[WIDTH];
  assign arr_y_prev = '0;
  assign busy       = (state != IDLE) || (inflight != '0) || !fifo_empty;

endmodule

// File: tb/tb_systolic_stream_ctrl.sv
// Bench for systolic_stream_ctrl: array stand-in y = 3*x, scoreboard of accepted samples.
module tb_systolic_stream_ctrl;

  localparam int WIDTH        = 8;
  localparam int LATENCY      = 3;
  localparam int DEPTH        = 4;
  localparam int FLUSH_CYCLES = 3;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    s_valid = 1'b0;
  logic                    s_last = 1'b0;
  logic                    m_ready = 1'b0;
  logic signed [WIDTH-1:0] s_data = '0;
  logic                    s_ready, m_valid, m_last, busy;
  logic signed [WIDTH-1:0] arr_x_in, arr_y_prev, arr_y_out, m_data;

  systolic_stream_ctrl #(
    .WIDTH(WIDTH), .LATENCY(LATENCY), .DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .arr_x_in(arr_x_in), .arr_y_prev(arr_y_prev), .arr_y_out(arr_y_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // array stand-in: y_out = 3*x_in, LATENCY cycles later
  logic signed [WIDTH-1:0] ypipe [LATENCY];
  always @(posedge clk) begin
    ypipe[0] <= WIDTH'(3 * arr_x_in);
    for (int i = 1; i < LATENCY; i++) ypipe[i] <= ypipe[i-1];
  end
  assign arr_y_out = ypipe[LATENCY-1];

  // Scoreboard: every accepted sample until popped, with the cycle it may appear
  typedef struct {
    logic signed [WIDTH-1:0] data;
    logic                    last;
    int                      rdy;
  } res_t;

  res_t                    q[$];
  int                      cyc = 0;
  int                      flush_left = 0;
  bit                      in_frame = 0;
  logic signed [WIDTH-1:0] exp_x = '0;
  int                      n_cmp = 0;
  int                      n_bad = 0;

  typedef struct {
    bit v; int d; bit l; bit r;
    bit e_rdy; bit e_mv; int e_md; bit e_ml; int e_x; bit e_busy;
  } vec_t;
  vec_t tbl[7];

  function automatic bit mdl_sready();
    return rst && (flush_left == 0) && (q.size() < DEPTH);
  endfunction

  function automatic bit mdl_mvalid();
    return (q.size() > 0) && (q[0].rdy <= cyc);
  endfunction

  function automatic bit mdl_busy();
    return in_frame || (flush_left > 0) || (q.size() > 0);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s cyc=%0d bound expired", name, cyc);
  endtask

  task automatic drive(input bit v, input int d, input bit l, input bit r);
    s_valid = v;
    s_data  = WIDTH'(d);
    s_last  = l;
    m_ready = r;
    #1;
  endtask

  task automatic check_model();
    chk("s_ready", s_ready, mdl_sready());
    chk("m_valid", m_valid, mdl_mvalid());
    if (mdl_mvalid()) begin
      chk("m_data", m_data, q[0].data);
      chk("m_last", m_last, q[0].last);
    end
    chk("arr_x_in", arr_x_in, exp_x);
    chk("arr_y_prev", arr_y_prev, 0);
    chk("busy", busy, mdl_busy());
  endtask

  task automatic advance();
    bit acc, pop;
    acc = s_valid && mdl_sready();
    pop = mdl_mvalid() && m_ready;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (acc) q.push_back('{data: WIDTH'(3 * s_data), last: s_last, rdy: cyc + 1 + LATENCY + 1});
    exp_x = acc ? s_data : '0;
    if (acc && s_last) begin
      flush_left = FLUSH_CYCLES;
      in_frame   = 0;
    end else begin
      if (flush_left > 0) flush_left--;
      if (acc) in_frame = 1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, r);
      check_model();
      advance();
    end
  endtask

  task automatic send(input int d, input bit l, input bit r);
    int guard;
    guard = 0;
    drive(1, d, l, r);
    while (!s_ready && guard < 50) begin
      check_model();
      advance();
      guard++;
    end
    if (guard >= 50) fail_now("send_wait");
    check_model();
    advance();
    drive(0, 0, 0, r);
  endtask

  task automatic apply_reset();
    s_valid = 0; s_last = 0; s_data = '0;
    rst = 1'b0;
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_arr_x_in", arr_x_in, 0);
    chk("rst_arr_y_prev", arr_y_prev, 0);
    chk("rst_busy", busy, 0);
    q.delete();
    flush_left = 0;
    in_frame   = 0;
    exp_x      = '0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((q.size() > 0 || busy) && guard < 200) begin
      drive(0, 0, 0, 1);
      check_model();
      advance();
      guard++;
    end
    if (guard >= 200) fail_now("drain");
  endtask

  initial begin
    int acc_cnt, k, lowcnt, guard;

    tbl[0] = '{1, 5, 1, 1,  1, 0, 0,  0, 0, 0};
    tbl[1] = '{0, 0, 0, 1,  0, 0, 0,  0, 5, 1};
    tbl[2] = '{0, 0, 0, 1,  0, 0, 0,  0, 0, 1};
    tbl[3] = '{0, 0, 0, 1,  0, 0, 0,  0, 0, 1};
    tbl[4] = '{0, 0, 0, 1,  1, 0, 0,  0, 0, 1};
    tbl[5] = '{0, 0, 0, 1,  1, 1, 15, 1, 0, 1};
    tbl[6] = '{0, 0, 0, 1,  1, 0, 0,  0, 0, 0};

    @(negedge clk);
    apply_reset();

    // single sample, hand-computed timeline
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r);
      chk("tbl_s_ready", s_ready, tbl[i].e_rdy);
      chk("tbl_m_valid", m_valid, tbl[i].e_mv);
      if (tbl[i].e_mv) begin
        chk("tbl_m_data", m_data, tbl[i].e_md);
        chk("tbl_m_last", m_last, tbl[i].e_ml);
      end
      chk("tbl_arr_x_in", arr_x_in, tbl[i].e_x);
      chk("tbl_busy", busy, tbl[i].e_busy);
      check_model();
      advance();
    end

    // one frame 1..8
    for (int i = 1; i <= 8; i++) send(i, i == 8, 1);
    drain();

    // backpressure: m_ready low for 20 cycles with a constant offer
    acc_cnt = 0;
    k = 1;
    for (int i = 0; i < 20; i++) begin
      drive(1, k, 0, 0);
      if (s_ready) begin
        acc_cnt++;
        k++;
      end
      check_model();
      advance();
    end
    chk("bp_accepts", acc_cnt, DEPTH);
    send(k, 1, 1);
    drain();

    // full FIFO with pulsed m_ready while samples keep arriving
    k = 20;
    for (int i = 0; i < 30; i++) begin
      drive(1, k, 0, (i >= 10) && (i % 3 == 0));
      if (s_ready) k++;
      check_model();
      advance();
    end
    send(k, 1, 1);
    drain();

    // reset with two results queued and two in flight
    for (int i = 1; i <= 4; i++) send(i, 0, 0);
    idle(2, 0);
    apply_reset();
    send(-2, 1, 1);
    drain();

    // frame A (1,2 last) then frame B (4) offered immediately
    send(1, 0, 1);
    send(2, 1, 1);
    lowcnt = 0;
    guard  = 0;
    drive(1, 4, 1, 1);
    while (!s_ready && guard < 50) begin
      lowcnt++;
      check_model();
      advance();
      guard++;
    end
    chk("flush_gap", lowcnt, FLUSH_CYCLES);
    check_model();
    advance();
    drain();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1) == 1, int'($urandom_range(0, 255)),
            $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0);
      check_model();
      advance();
    end
    send(7, 1, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
